// File: rtl/dht_sched_pkg.sv
// Shared types and constants for the DHT11 read scheduler: FSM states, command
// and status byte values, counter width and the sensor checksum rule.
package dht_sched_pkg;

  localparam int unsigned CNT_W = 27;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StHoldoff,
    StTrig,
    StArm,
    StWaitRd,
    StCheck,
    StResp
  } state_e;

  localparam logic [7:0] CMD_HUM   = 8'h01;
  localparam logic [7:0] CMD_TEMP  = 8'h02;
  localparam logic [7:0] CMD_STAT  = 8'h03;
  localparam logic [7:0] CMD_FORCE = 8'h04;

  localparam logic [7:0] ST_OK_CACHE = 8'h00;
  localparam logic [7:0] ST_OK_NEW   = 8'h01;
  localparam logic [7:0] ST_RD_ERR   = 8'hE0;
  localparam logic [7:0] ST_CRC_ERR  = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT  = 8'hE2;
  localparam logic [7:0] ST_INVALID  = 8'hEF;

  // DHT11 checksum is the low byte of the sum of the four data bytes.
  function automatic logic crc_ok(input logic [7:0] hi, input logic [7:0] hf,
                                  input logic [7:0] ti, input logic [7:0] tf,
                                  input logic [7:0] crc);
    logic [7:0] sum;
    sum = hi + hf + ti + tf;
    return sum == crc;
  endfunction

endpackage

// File: rtl/dht11_read_scheduler_if.sv
// Command/response handshake plus DHT11 reader hookup for the read scheduler.
// The slave view belongs to the scheduler; master is the surrounding system.
interface dht11_read_scheduler_if;
  logic       REQ_VALID;
  logic [7:0] REQ_CMD;
  logic       REQ_READY;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic [7:0] RSP_CODE;
  logic [7:0] RSP_DATA;
  logic       SENS_EN;
  logic       SENS_RST;
  logic       SENS_WAIT;
  logic       SENS_ERROR;
  logic [7:0] SENS_HUM_INT;
  logic [7:0] SENS_HUM_FLOAT;
  logic [7:0] SENS_TEMP_INT;
  logic [7:0] SENS_TEMP_FLOAT;
  logic [7:0] SENS_CRC;
  logic       BUSY;

  modport master (
    output REQ_VALID, REQ_CMD, RSP_READY, SENS_WAIT, SENS_ERROR,
    output SENS_HUM_INT, SENS_HUM_FLOAT, SENS_TEMP_INT, SENS_TEMP_FLOAT, SENS_CRC,
    input  REQ_READY, RSP_VALID, RSP_CODE, RSP_DATA, SENS_EN, SENS_RST, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_CMD, RSP_READY, SENS_WAIT, SENS_ERROR,
    input  SENS_HUM_INT, SENS_HUM_FLOAT, SENS_TEMP_INT, SENS_TEMP_FLOAT, SENS_CRC,
    output REQ_READY, RSP_VALID, RSP_CODE, RSP_DATA, SENS_EN, SENS_RST, BUSY
  );
endinterface

// File: rtl/dht_age_timer.sv
// Saturating age counter: time since the last sensor result, clamped at the
// trigger gap. gap_ok marks that a new trigger is allowed.
module dht_age_timer
  import dht_sched_pkg::*;
#(
  parameter int unsigned MIN_GAP_CYC = 100000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  output logic [CNT_W-1:0] age,
  output logic             gap_ok
);

  localparam logic [CNT_W-1:0] GapMax = CNT_W'(MIN_GAP_CYC);

  logic [CNT_W-1:0] age_q;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      age_q <= '0;
    end else if (age_q != GapMax) begin
      age_q <= age_q + CNT_W'(1);
    end
  end

  assign age    = age_q;
  assign gap_ok = (age_q == GapMax);

endmodule

// File: rtl/dht11_read_scheduler.sv
// Serves DHT11 read commands from a cached sample while fresh, otherwise runs a
// rate-limited, retried sensor transaction and returns one code/data response.
module dht11_read_scheduler
  import dht_sched_pkg::*;
#(
  parameter int unsigned MIN_GAP_CYC = 100000000,
  parameter int unsigned ARM_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 10000000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input logic                   CLK,
  input logic                   RST,
  dht11_read_scheduler_if.slave bus
);

  if (MIN_GAP_CYC < 1 || MIN_GAP_CYC >= (32'd1 << CNT_W) ||
      ARM_CYC < 1 || ARM_CYC >= (32'd1 << CNT_W) ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (32'd1 << CNT_W) || MAX_RETRY > 3) begin : g_param_chk
    $error("dht11_read_scheduler: parameter out of range");
  end

  localparam logic [CNT_W-1:0] GapMax   = CNT_W'(MIN_GAP_CYC);
  localparam logic [CNT_W-1:0] ArmLast  = CNT_W'(ARM_CYC - 1);
  localparam logic [CNT_W-1:0] TmoLast  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       RetryMax = 2'(MAX_RETRY);

  state_e           state_q;
  logic [7:0]       cmd_q, hum_q, temp_q;
  logic [CNT_W-1:0] cnt_q, age;
  logic [1:0]       retry_q, last_retries_q;
  logic             cache_valid_q, req_ready_q, rsp_valid_q, trig_q, busy_q;
  logic [7:0]       rsp_code_q, rsp_data_q, fail_code;
  logic             gap_ok, fresh, crc_good, arm_fail, rd_err, rd_tmo, crc_fail, fail, age_clr;

  dht_age_timer #(
    .MIN_GAP_CYC(MIN_GAP_CYC)
  ) u_age (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (age_clr),
    .age   (age),
    .gap_ok(gap_ok)
  );

  assign fresh    = cache_valid_q && (age < GapMax);
  assign crc_good = crc_ok(bus.SENS_HUM_INT, bus.SENS_HUM_FLOAT, bus.SENS_TEMP_INT,
                           bus.SENS_TEMP_FLOAT, bus.SENS_CRC);

  // Every transaction end restarts the gap, so retries are spaced like triggers.
  always_comb begin
    arm_fail  = (state_q == StArm) && !bus.SENS_WAIT && (cnt_q == ArmLast);
    rd_err    = (state_q == StWaitRd) && bus.SENS_ERROR;
    rd_tmo    = (state_q == StWaitRd) && !bus.SENS_ERROR && bus.SENS_WAIT && (cnt_q == TmoLast);
    crc_fail  = (state_q == StCheck) && !crc_good;
    fail      = arm_fail || rd_err || rd_tmo || crc_fail;
    age_clr   = (state_q == StCheck) || arm_fail || rd_err || rd_tmo;
    fail_code = ST_TIMEOUT;
    if (rd_err) begin
      fail_code = ST_RD_ERR;
    end else if (crc_fail) begin
      fail_code = ST_CRC_ERR;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      cmd_q          <= '0;
      cnt_q          <= '0;
      retry_q        <= '0;
      last_retries_q <= '0;
      cache_valid_q  <= 1'b0;
      hum_q          <= '0;
      temp_q         <= '0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_code_q     <= '0;
      rsp_data_q     <= '0;
      trig_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else if (fail) begin
      busy_q <= 1'b0;
      if (retry_q < RetryMax) begin
        retry_q <= retry_q + 2'd1;
        state_q <= StHoldoff;
      end else begin
        rsp_code_q     <= fail_code;
        rsp_data_q     <= 8'h00;
        last_retries_q <= retry_q;
        retry_q        <= '0;
        state_q        <= StResp;
      end
    end else begin
      case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (bus.REQ_VALID && req_ready_q) begin
            req_ready_q <= 1'b0;
            cmd_q       <= bus.REQ_CMD;
            state_q     <= StDecode;
          end
        end
        StDecode: begin
          state_q    <= StResp;
          rsp_code_q <= ST_OK_CACHE;
          case (cmd_q)
            CMD_HUM:   if (fresh) rsp_data_q <= hum_q;  else state_q <= StHoldoff;
            CMD_TEMP:  if (fresh) rsp_data_q <= temp_q; else state_q <= StHoldoff;
            CMD_STAT:  rsp_data_q <= {cache_valid_q, fresh, busy_q, 3'b000, last_retries_q};
            CMD_FORCE: state_q <= StHoldoff;
            default: begin
              rsp_code_q <= ST_INVALID;
              rsp_data_q <= cmd_q;
            end
          endcase
        end
        StHoldoff: begin
          if (gap_ok) begin
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StTrig;
          end
        end
        StTrig: begin
          trig_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= StArm;
        end
        StArm: begin
          if (bus.SENS_WAIT) begin
            cnt_q   <= '0;
            state_q <= StWaitRd;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWaitRd: begin
          if (!bus.SENS_WAIT) state_q <= StCheck;
          else                cnt_q   <= cnt_q + CNT_W'(1);
        end
        StCheck: begin
          // Reached only with a good checksum; bad ones take the fail path.
          cache_valid_q  <= 1'b1;
          hum_q          <= bus.SENS_HUM_INT;
          temp_q         <= bus.SENS_TEMP_INT;
          busy_q         <= 1'b0;
          rsp_code_q     <= ST_OK_NEW;
          rsp_data_q     <= (cmd_q == CMD_HUM) ? bus.SENS_HUM_INT : bus.SENS_TEMP_INT;
          last_retries_q <= retry_q;
          retry_q        <= '0;
          state_q        <= StResp;
        end
        StResp: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.REQ_READY = req_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_CODE  = rsp_code_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.SENS_EN   = 1'b1;
  assign bus.SENS_RST  = RST || trig_q;
  assign bus.BUSY      = busy_q;

endmodule
